// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx serializer among N_REQ requesters.
// uart_tx has no ready output, so this block paces launches: one i_vld pulse per byte,
// then a full frame plus guard of dead time before the next accept.
module uart_tx_arb #(
  parameter int unsigned FREQ  = 1_000_000,
  parameter int unsigned RATE  = 115_200,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GUARD = 2,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]   i_req_vld,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_rdy,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_vld,
  output logic               o_busy,
  output logic [IW-1:0]      o_gnt_id
);

  localparam int unsigned BIT_CYC   = FREQ / RATE;
  localparam int unsigned FRAME_CYC = 10 * BIT_CYC + GUARD;
  localparam int unsigned CW        = $clog2(FRAME_CYC + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e        r_state, w_state_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          r_busy, w_busy_d;
  logic [IW-1:0] r_ptr;
  logic [7:0]    r_tx_data;
  logic [IW-1:0] r_gnt_id;

  logic [IW-1:0] w_cand [N_REQ];
  logic          w_sel_vld;
  logic [IW-1:0] w_sel_idx;
  logic [7:0]    w_sel_data;
  logic          w_accept;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_idx  = '0;
    w_sel_data = 8'h00;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_cand[i] = IW'((32'(r_ptr) + i + 1) % N_REQ);
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_sel_vld && i_req_vld[w_cand[i]]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_cand[i];
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_sel_idx == IW'(k)) w_sel_data = i_req_data[8*k +: 8];
    end
  end

  assign w_accept = (r_state == StIdle) && !rst && w_sel_vld;

  // One-hot ready for the selected requester, only while idle and out of reset.
  always_comb begin
    o_req_rdy = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      o_req_rdy[k] = w_accept && (w_sel_idx == IW'(k));
    end
  end

  // Next-state logic. The counter is loaded at accept so that it already runs during the
  // launch cycle; the next accept lands exactly FRAME_CYC+1 cycles after the previous one.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_busy_d  = r_busy;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StLaunch;
          w_cnt_d   = CW'(FRAME_CYC - 1);
          w_busy_d  = 1'b1;
        end
      end
      StLaunch: begin
        w_state_d = StWait;
        w_cnt_d   = r_cnt - 1'b1;
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  // State, pacing counter and accept-time captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_ptr     <= IW'(N_REQ - 1);
      r_tx_data <= 8'h00;
      r_gnt_id  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= w_busy_d;
      if (w_accept) begin
        r_ptr     <= w_sel_idx;
        r_tx_data <= w_sel_data;
        r_gnt_id  <= w_sel_idx;
      end
    end
  end

  assign o_tx_vld  = (r_state == StLaunch);
  assign o_tx_data = r_tx_data;
  assign o_busy    = r_busy;
  assign o_gnt_id  = r_gnt_id;

endmodule
